// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes, burst codes,
// write/read FSM state encodings, the latched address-phase context and
// an address-window helper.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_WAIT = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   // Address-phase context captured on an AW or AR handshake
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
   } ax_ctx_t;

   // True when addr lies in [base, base+bytes); the subtraction wraps so
   // addresses below base land far above bytes.
   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] bytes);
      logic [31:0] off;
      off = addr - base;
      return off < bytes;
   endfunction

endpackage

// File: rtl/sram_bytewr.sv
// Word-organised storage with one byte-enabled synchronous write port and
// one asynchronous read port. Contents are never reset.
// Ports: clock; we/wbe/waddr/wdata write port; raddr -> rdata read port.
module sram_bytewr #(
   parameter int unsigned WORDS = 4096,
   parameter int unsigned IDX_W = $clog2(WORDS)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [3:0]       wbe,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [WORDS];

   // Byte-lane write
   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst slave in front of a word SRAM. Independent write
// (AW/W/B) and read (AR/R) state machines share only the storage.
// Ports: clock, reset (sync, active-high); io_slave_aw*/w*/b* write
// channels; io_slave_ar*/r* read channels. Size and burst type inputs are
// accepted but ignored: wstrb selects bytes, reads return full words.
module axi_sram_slave
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned RD_LAT    = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        io_slave_awready,
   input  logic        io_slave_awvalid,
   input  logic [31:0] io_slave_awaddr,
   input  logic [3:0]  io_slave_awid,
   input  logic [7:0]  io_slave_awlen,
   input  logic [2:0]  io_slave_awsize,
   input  logic [1:0]  io_slave_awburst,
   output logic        io_slave_wready,
   input  logic        io_slave_wvalid,
   input  logic [31:0] io_slave_wdata,
   input  logic [3:0]  io_slave_wstrb,
   input  logic        io_slave_wlast,
   input  logic        io_slave_bready,
   output logic        io_slave_bvalid,
   output logic [1:0]  io_slave_bresp,
   output logic [3:0]  io_slave_bid,
   output logic        io_slave_arready,
   input  logic        io_slave_arvalid,
   input  logic [31:0] io_slave_araddr,
   input  logic [3:0]  io_slave_arid,
   input  logic [7:0]  io_slave_arlen,
   input  logic [2:0]  io_slave_arsize,
   input  logic [1:0]  io_slave_arburst,
   input  logic        io_slave_rready,
   output logic        io_slave_rvalid,
   output logic [31:0] io_slave_rdata,
   output logic [1:0]  io_slave_rresp,
   output logic        io_slave_rlast,
   output logic [3:0]  io_slave_rid
);

   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

   // Inputs and constants deliberately not consumed by the datapath
   logic unused_ok;
   assign unused_ok = ^{io_slave_awsize, io_slave_awburst, io_slave_awaddr[1:0],
                        io_slave_arsize, io_slave_arburst, io_slave_araddr[1:0],
                        BURST_FIXED, BURST_INCR, BURST_WRAP};

   logic [1:0]       w_state_q, w_state_d;
   ax_ctx_t          aw_q, aw_d;
   logic [7:0]       w_beat_q, w_beat_d;
   logic             w_slverr_q, w_slverr_d;
   logic             w_decerr_q, w_decerr_d;
   logic             mem_we_c, w_hit_c, w_last_c;
   logic [IDX_W-1:0] w_idx_c;

   logic [1:0]       r_state_q, r_state_d;
   ax_ctx_t          ar_q, ar_d;
   logic [7:0]       r_beat_q, r_beat_d;
   logic [3:0]       r_dly_q, r_dly_d;
   logic             r_hit_c, r_last_c;
   logic [IDX_W-1:0] r_idx_c;
   logic [31:0]      mem_rdata_c;

   assign w_hit_c  = addr_hit(aw_q.addr, BASE_ADDR, MEM_BYTES);
   assign w_idx_c  = IDX_W'((aw_q.addr - BASE_ADDR) >> 2);
   assign w_last_c = (w_beat_q == aw_q.len);

   // Write FSM next state; out-of-range beats are dropped and flagged
   always_comb begin
      w_state_d  = w_state_q;
      aw_d       = aw_q;
      w_beat_d   = w_beat_q;
      w_slverr_d = w_slverr_q;
      w_decerr_d = w_decerr_q;
      mem_we_c   = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (io_slave_awvalid) begin
               aw_d.addr  = {io_slave_awaddr[31:2], 2'b00};
               aw_d.id    = io_slave_awid;
               aw_d.len   = io_slave_awlen;
               w_beat_d   = 8'd0;
               w_slverr_d = 1'b0;
               w_decerr_d = 1'b0;
               w_state_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (io_slave_wvalid) begin
               mem_we_c = w_hit_c;
               if (!w_hit_c) w_decerr_d = 1'b1;
               if (io_slave_wlast != w_last_c) w_slverr_d = 1'b1;
               aw_d.addr = aw_q.addr + 32'd4;
               w_beat_d  = w_beat_q + 8'd1;
               if (w_last_c) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (io_slave_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q  <= W_IDLE;
         aw_q       <= '0;
         w_beat_q   <= 8'd0;
         w_slverr_q <= 1'b0;
         w_decerr_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_q       <= aw_d;
         w_beat_q   <= w_beat_d;
         w_slverr_q <= w_slverr_d;
         w_decerr_q <= w_decerr_d;
      end
   end

   assign io_slave_awready = (w_state_q == W_IDLE);
   assign io_slave_wready  = (w_state_q == W_DATA);
   assign io_slave_bvalid  = (w_state_q == W_RESP);
   assign io_slave_bid     = aw_q.id;
   // DECERR takes priority over SLVERR
   assign io_slave_bresp   = !io_slave_bvalid ? RESP_OKAY :
                             w_decerr_q        ? RESP_DECERR :
                             w_slverr_q        ? RESP_SLVERR : RESP_OKAY;

   assign r_hit_c  = addr_hit(ar_q.addr, BASE_ADDR, MEM_BYTES);
   assign r_idx_c  = IDX_W'((ar_q.addr - BASE_ADDR) >> 2);
   assign r_last_c = (r_beat_q == ar_q.len);

   // Read FSM next state; R_DATA is entered on the edge the delay hits 0
   always_comb begin
      r_state_d = r_state_q;
      ar_d      = ar_q;
      r_beat_d  = r_beat_q;
      r_dly_d   = r_dly_q;
      case (r_state_q)
         R_IDLE: begin
            if (io_slave_arvalid) begin
               ar_d.addr = {io_slave_araddr[31:2], 2'b00};
               ar_d.id   = io_slave_arid;
               ar_d.len  = io_slave_arlen;
               r_beat_d  = 8'd0;
               r_dly_d   = 4'(RD_LAT);
               r_state_d = (RD_LAT == 0) ? R_DATA : R_WAIT;
            end
         end
         R_WAIT: begin
            r_dly_d = r_dly_q - 4'd1;
            if (r_dly_q <= 4'd1) r_state_d = R_DATA;
         end
         R_DATA: begin
            if (io_slave_rready) begin
               ar_d.addr = ar_q.addr + 32'd4;
               r_beat_d  = r_beat_q + 8'd1;
               if (r_last_c) r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         ar_q      <= '0;
         r_beat_q  <= 8'd0;
         r_dly_q   <= 4'd0;
      end else begin
         r_state_q <= r_state_d;
         ar_q      <= ar_d;
         r_beat_q  <= r_beat_d;
         r_dly_q   <= r_dly_d;
      end
   end

   // Asynchronous read path so a same-word write is visible the next cycle
   assign io_slave_arready = (r_state_q == R_IDLE);
   assign io_slave_rvalid  = (r_state_q == R_DATA);
   assign io_slave_rid     = ar_q.id;
   assign io_slave_rlast   = io_slave_rvalid && r_last_c;
   assign io_slave_rdata   = (io_slave_rvalid && r_hit_c) ? mem_rdata_c : 32'd0;
   assign io_slave_rresp   = (io_slave_rvalid && !r_hit_c) ? RESP_DECERR : RESP_OKAY;

   sram_bytewr #(.WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_sram (
      .clock (clock),
      .we    (mem_we_c),
      .wbe   (io_slave_wstrb),
      .waddr (w_idx_c),
      .wdata (io_slave_wdata),
      .raddr (r_idx_c),
      .rdata (mem_rdata_c)
   );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (RD_LAT = 2).
module tb_axi_sram_slave;

   logic        clock, reset;
   logic        awready, awvalid;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wready, wvalid, wlast;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bready, bvalid;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arready, arvalid;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rready, rvalid, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [31:0] rd_sdata [16];
   logic        rd_slast [16];
   logic        rd_svalid [16];
   logic [3:0]  rd_id;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   int          lat;
   logic [31:0] exp_d [4];

   axi_sram_slave #(.BASE_ADDR(32'h8000_0000), .MEM_WORDS(4096), .RD_LAT(2)) dut (
      .clock            (clock),
      .reset            (reset),
      .io_slave_awready (awready),
      .io_slave_awvalid (awvalid),
      .io_slave_awaddr  (awaddr),
      .io_slave_awid    (awid),
      .io_slave_awlen   (awlen),
      .io_slave_awsize  (awsize),
      .io_slave_awburst (awburst),
      .io_slave_wready  (wready),
      .io_slave_wvalid  (wvalid),
      .io_slave_wdata   (wdata),
      .io_slave_wstrb   (wstrb),
      .io_slave_wlast   (wlast),
      .io_slave_bready  (bready),
      .io_slave_bvalid  (bvalid),
      .io_slave_bresp   (bresp),
      .io_slave_bid     (bid),
      .io_slave_arready (arready),
      .io_slave_arvalid (arvalid),
      .io_slave_araddr  (araddr),
      .io_slave_arid    (arid),
      .io_slave_arlen   (arlen),
      .io_slave_arsize  (arsize),
      .io_slave_arburst (arburst),
      .io_slave_rready  (rready),
      .io_slave_rvalid  (rvalid),
      .io_slave_rdata   (rdata),
      .io_slave_rresp   (rresp),
      .io_slave_rlast   (rlast),
      .io_slave_rid     (rid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full write burst from wr_data/wr_strb; wlast driven on beat wl_beat
   task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int wl_beat, output logic [1:0] resp, output logic [3:0] id_o);
      int n;
      logic tmo;
      tmo = 1'b0;
      awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin tick(); n++; end
      if (n >= 100) tmo = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata = wr_data[b]; wstrb = wr_strb[b]; wlast = (b == wl_beat); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 100) begin tick(); n++; end
         if (n >= 100) tmo = 1'b1;
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 100) begin tick(); n++; end
      if (n >= 100) tmo = 1'b1;
      resp = bresp; id_o = bid;
      tick();
      bready = 1'b0;
      check_val("write_timeout", 32'(tmo), 32'd0);
   endtask

   // Full read burst; with stall set each beat sees one rready=0 cycle first
   task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input bit stall, output int lat_o);
      int n;
      logic tmo;
      tmo = 1'b0;
      araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin tick(); n++; end
      if (n >= 100) tmo = 1'b1;
      tick();
      arvalid = 1'b0;
      lat_o = 1;
      while (!rvalid && lat_o < 100) begin tick(); lat_o++; end
      if (lat_o >= 100) tmo = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         if (stall) begin
            rready = 1'b0;
            rd_sdata[b] = rdata; rd_slast[b] = rlast; rd_svalid[b] = rvalid;
            tick();
         end
         rready = 1'b1;
         n = 0;
         while (!rvalid && n < 100) begin tick(); n++; end
         if (n >= 100) tmo = 1'b1;
         rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id = rid;
         tick();
      end
      rready = 1'b0;
      check_val("read_timeout", 32'(tmo), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
      wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
      arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
      rready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_awready", 32'(awready), 32'd1);
      check_val("rst_arready", 32'(arready), 32'd1);
      check_val("rst_wready",  32'(wready),  32'd0);
      check_val("rst_bvalid",  32'(bvalid),  32'd0);
      check_val("rst_rvalid",  32'(rvalid),  32'd0);
      check_val("rst_rlast",   32'(rlast),   32'd0);
      check_val("rst_bresp",   32'(bresp),   32'd0);
      check_val("rst_rresp",   32'(rresp),   32'd0);
      check_val("rst_bid",     32'(bid),     32'd0);
      check_val("rst_rid",     32'(rid),     32'd0);
      check_val("rst_rdata",   rdata,        32'd0);
      reset = 1'b0;
      tick();

      // Single-beat write then read: latency 3 with RD_LAT=2
      wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
      axi_write(32'h8000_0000, 4'h5, 8'd0, 0, b_resp, b_id);
      check_val("t1_bresp", 32'(b_resp), 32'd0);
      check_val("t1_bid",   32'(b_id),   32'd5);
      axi_read(32'h8000_0000, 4'h9, 8'd0, 1'b0, lat);
      check_val("t1_latency", 32'(lat), 32'd3);
      check_val("t1_rdata", rd_data[0], 32'hDEAD_BEEF);
      check_val("t1_rlast", 32'(rd_last[0]), 32'd1);
      check_val("t1_rresp", 32'(rd_resp[0]), 32'd0);
      check_val("t1_rid",   32'(rd_id), 32'd9);

      // Prefill words 4..7, then overwrite with a partial strobe on beat 2
      wr_data[0] = 32'hA0A0_A0A0; wr_data[1] = 32'hB1B1_B1B1;
      wr_data[2] = 32'hC2C2_C2C2; wr_data[3] = 32'hD3D3_D3D3;
      for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
      axi_write(32'h8000_0010, 4'h1, 8'd3, 3, b_resp, b_id);
      check_val("t2_pre_bresp", 32'(b_resp), 32'd0);
      wr_data[0] = 32'h1111_2222; wr_data[1] = 32'h3333_4444;
      wr_data[2] = 32'h5566_7788; wr_data[3] = 32'h9999_AAAA;
      wr_strb[2] = 4'b0011;
      axi_write(32'h8000_0010, 4'h2, 8'd3, 3, b_resp, b_id);
      check_val("t2_bresp", 32'(b_resp), 32'd0);
      check_val("t2_bid",   32'(b_id),   32'd2);
      exp_d[0] = 32'h1111_2222; exp_d[1] = 32'h3333_4444;
      exp_d[2] = 32'hC2C2_7788; exp_d[3] = 32'h9999_AAAA;
      axi_read(32'h8000_0010, 4'h3, 8'd3, 1'b1, lat);
      for (int b = 0; b < 4; b++) begin
         check_val($sformatf("t3_rdata_b%0d", b),       rd_data[b],  exp_d[b]);
         check_val($sformatf("t3_stall_rdata_b%0d", b), rd_sdata[b], exp_d[b]);
         check_val($sformatf("t3_rlast_b%0d", b),       32'(rd_last[b]),  32'(b == 3));
         check_val($sformatf("t3_stall_rlast_b%0d", b), 32'(rd_slast[b]), 32'(b == 3));
         check_val($sformatf("t3_stall_rvalid_b%0d", b), 32'(rd_svalid[b]), 32'd1);
         check_val($sformatf("t3_rresp_b%0d", b),       32'(rd_resp[b]),  32'd0);
      end
      check_val("t3_rvalid_after", 32'(rvalid), 32'd0);

      // Out-of-range write is dropped (0x7000_0000 aliases word 0's index)
      for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
      wr_data[0] = 32'hFFFF_FFFF;
      axi_write(32'h7000_0000, 4'h4, 8'd0, 0, b_resp, b_id);
      check_val("t4_bresp", 32'(b_resp), 32'd3);
      axi_read(32'h8000_0000, 4'h0, 8'd0, 1'b0, lat);
      check_val("t4_word0_kept", rd_data[0], 32'hDEAD_BEEF);
      axi_read(32'h7000_0000, 4'h6, 8'd0, 1'b0, lat);
      check_val("t4_oor_rdata", rd_data[0], 32'd0);
      check_val("t4_oor_rresp", 32'(rd_resp[0]), 32'd3);
      check_val("t4_oor_rlast", 32'(rd_last[0]), 32'd1);

      // Burst running off the top of memory: beat 1 is out of range
      wr_data[0] = 32'h0BAD_F00D; wr_data[1] = 32'h1212_1212;
      axi_write(32'h8000_3FFC, 4'h7, 8'd1, 1, b_resp, b_id);
      check_val("t5_bresp", 32'(b_resp), 32'd3);
      axi_read(32'h8000_3FFC, 4'h7, 8'd1, 1'b0, lat);
      check_val("t5_rdata_b0", rd_data[0], 32'h0BAD_F00D);
      check_val("t5_rresp_b0", 32'(rd_resp[0]), 32'd0);
      check_val("t5_rlast_b0", 32'(rd_last[0]), 32'd0);
      check_val("t5_rdata_b1", rd_data[1], 32'd0);
      check_val("t5_rresp_b1", 32'(rd_resp[1]), 32'd3);
      check_val("t5_rlast_b1", 32'(rd_last[1]), 32'd1);

      // Early wlast: all three beats still written, SLVERR reported
      wr_data[0] = 32'h0101_0101; wr_data[1] = 32'h0202_0202; wr_data[2] = 32'h0303_0303;
      axi_write(32'h8000_0100, 4'h8, 8'd2, 1, b_resp, b_id);
      check_val("t6_bresp", 32'(b_resp), 32'd2);
      check_val("t6_bid",   32'(b_id),   32'd8);
      axi_read(32'h8000_0100, 4'hA, 8'd2, 1'b0, lat);
      check_val("t6_rdata_b0", rd_data[0], 32'h0101_0101);
      check_val("t6_rdata_b1", rd_data[1], 32'h0202_0202);
      check_val("t6_rdata_b2", rd_data[2], 32'h0303_0303);

      // Low address bits are ignored
      axi_read(32'h8000_0013, 4'hB, 8'd0, 1'b0, lat);
      check_val("t7_unaligned", rd_data[0], 32'h1111_2222);

      // Reset while the read is waiting out its latency
      araddr = 32'h8000_0000; arid = 4'hC; arlen = 8'd0; arvalid = 1'b1;
      check_val("t8_arready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      reset = 1'b1;
      tick();
      check_val("t8_rvalid", 32'(rvalid), 32'd0);
      check_val("t8_arready_rst", 32'(arready), 32'd1);
      reset = 1'b0;
      repeat (5) tick();
      check_val("t8_rvalid_later", 32'(rvalid), 32'd0);
      axi_read(32'h8000_0000, 4'hD, 8'd0, 1'b0, lat);
      check_val("t8_mem_retained", rd_data[0], 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
